// File: rtl/bingo_inter_pkg.sv
// Shared definitions for the bingo interboard link: message encodings,
// field widths, scheduler state encoding and a small index helper.
package bingo_inter_pkg;

    localparam int MSG_W = 3;
    localparam int NUM_W = 5;

    localparam logic [MSG_W-1:0] MSG_NOP    = 3'd0;
    localparam logic [MSG_W-1:0] MSG_START  = 3'd1;
    localparam logic [MSG_W-1:0] MSG_NUMBER = 3'd2;
    localparam logic [MSG_W-1:0] MSG_BINGO  = 3'd3;
    localparam logic [MSG_W-1:0] MSG_RESET  = 3'd4;
    localparam logic [MSG_W-1:0] MSG_STATUS = 3'd5;

    typedef enum logic [1:0] {
        TXS_IDLE       = 2'd0,
        TXS_ISSUE      = 2'd1,
        TXS_WAIT_START = 2'd2,
        TXS_WAIT_DONE  = 2'd3
    } txs_state_t;

    // (base + off) modulo n, for base, off < n
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/interboard_tx_scheduler_if.sv
// Requester-side and transmitter-side handshake bundle of the scheduler.
// master: the scheduler; slave: the message sources plus the transmitter.
interface interboard_tx_scheduler_if
    import bingo_inter_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [MSG_W*NUM_REQ-1:0] req_msg_type;
    logic [NUM_W*NUM_REQ-1:0] req_number;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     inter_ready;
    logic                     transmit;
    logic                     ctrl_en;
    logic [MSG_W-1:0]         ctrl_msg_type;
    logic [NUM_W-1:0]         ctrl_number;

    modport master (
        input  req_valid, req_msg_type, req_number, inter_ready,
        output req_ready, transmit, ctrl_en, ctrl_msg_type, ctrl_number
    );

    modport slave (
        output req_valid, req_msg_type, req_number, inter_ready,
        input  req_ready, transmit, ctrl_en, ctrl_msg_type, ctrl_number
    );
endinterface

// File: rtl/interboard_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter with optional fixed priority for requester 0.
// Grant is combinational; the pointer advances only when told to.
module rr_arbiter
    import bingo_inter_pkg::*;
#(
    parameter  int NUM_REQ   = 3,
    parameter  int FIX_PRIO0 = 1,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);
    localparam bit PRIO0_EN = (FIX_PRIO0 != 0);
    // With fixed priority, index 0 never needs a round-robin turn
    localparam logic [IDX_W-1:0] PTR_RST = (PRIO0_EN && NUM_REQ > 1) ? IDX_W'(32'd1) : '0;

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] k_s;
    logic             hit_s;

    // Grant scan: port 0 pre-empts under fixed priority, else first valid from the pointer onward
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        k_s       = '0;
        hit_s     = 1'b0;
        if (PRIO0_EN && valid[0]) begin
            grant[0] = 1'b1;
            any      = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                k_s       = IDX_W'(wrap_add(32'(ptr_r), 32'(i), 32'(NUM_REQ)));
                hit_s     = !any && valid[k_s] && !(PRIO0_EN && (k_s == '0));
                grant[k_s] = grant[k_s] | hit_s;
                grant_idx = hit_s ? k_s : grant_idx;
                any       = any | hit_s;
            end
        end
    end

    // Pointer moves just past the granted index on each advancing accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= PTR_RST;
        end else if (advance) begin
            ptr_r <= IDX_W'(wrap_add(32'(grant_idx), 32'd1, 32'(NUM_REQ)));
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: rtl/interboard_tx_scheduler.sv
// Shares the single interboard transmitter among NUM_REQ message sources:
// arbitrates, latches one message, pulses transmit, follows inter_ready
// through busy/done and recovers on timeout or link abort.
// START_TO counts cycles from the transmit pulse (inclusive); must be >= 2.
module interboard_tx_scheduler
    import bingo_inter_pkg::*;
#(
    parameter  int NUM_REQ   = 3,
    parameter  int FIX_PRIO0 = 1,
    parameter  int START_TO  = 16,
    parameter  int DONE_TO   = 1_000_000,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = $clog2(DONE_TO + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          interboard_rst,
    interboard_tx_scheduler_if.master     bus,
    output logic                          busy,
    output logic [NUM_REQ-1:0]            last_grant,
    output logic                          timeout_err
);
    localparam logic [1:0] ST_IDLE       = TXS_IDLE;
    localparam logic [1:0] ST_ISSUE      = TXS_ISSUE;
    localparam logic [1:0] ST_WAIT_START = TXS_WAIT_START;
    localparam logic [1:0] ST_WAIT_DONE  = TXS_WAIT_DONE;

    // WAIT_START is entered one cycle after the pulse, hence the -2
    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 2);
    localparam logic [CNT_W-1:0] DONE_LIM  = CNT_W'(DONE_TO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               transmit_r;
    logic               ctrl_en_r;
    logic [MSG_W-1:0]   msg_r;
    logic [NUM_W-1:0]   num_r;
    logic [NUM_REQ-1:0] last_grant_r;
    logic               timeout_err_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   idx_s;
    logic               any_s;
    logic               accept_s;
    logic               advance_s;
    logic [MSG_W-1:0]   sel_msg_s;
    logic [NUM_W-1:0]   sel_num_s;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .FIX_PRIO0 (FIX_PRIO0)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (bus.req_valid),
        .advance   (advance_s),
        .grant     (grant_s),
        .grant_idx (idx_s),
        .any       (any_s)
    );

    assign accept_s  = (state_r == ST_IDLE) && bus.inter_ready && any_s && !interboard_rst;
    assign advance_s = accept_s && !((FIX_PRIO0 != 0) && (idx_s == '0));
    assign sel_msg_s = bus.req_msg_type[idx_s*MSG_W +: MSG_W];
    assign sel_num_s = bus.req_number[idx_s*NUM_W +: NUM_W];
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    assign bus.req_ready     = accept_s ? grant_s : '0;
    assign bus.transmit      = transmit_r;
    assign bus.ctrl_en       = ctrl_en_r;
    assign bus.ctrl_msg_type = msg_r;
    assign bus.ctrl_number   = num_r;
    assign busy              = (state_r != ST_IDLE);
    assign last_grant        = last_grant_r;
    assign timeout_err       = timeout_err_r;

    // Message FSM: accept, pulse transmit, follow the transmitter handshake, recover on timeout/abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            transmit_r    <= 1'b0;
            ctrl_en_r     <= 1'b0;
            msg_r         <= '0;
            num_r         <= '0;
            last_grant_r  <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            transmit_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            if (interboard_rst) begin
                // Link abort outranks any timeout or inter_ready edge this cycle
                state_r   <= ST_IDLE;
                cnt_r     <= '0;
                ctrl_en_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        cnt_r <= '0;
                        if (accept_s) begin
                            msg_r        <= sel_msg_s;
                            num_r        <= sel_num_s;
                            ctrl_en_r    <= 1'b1;
                            last_grant_r <= grant_s;
                            transmit_r   <= 1'b1;
                            state_r      <= ST_ISSUE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ISSUE: begin
                        cnt_r   <= '0;
                        state_r <= ST_WAIT_START;
                    end
                    ST_WAIT_START: begin
                        if (!bus.inter_ready) begin
                            cnt_r   <= '0;
                            state_r <= ST_WAIT_DONE;
                        end else if (cnt_r >= START_LIM) begin
                            cnt_r         <= '0;
                            timeout_err_r <= 1'b1;
                            ctrl_en_r     <= 1'b0;
                            state_r       <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (bus.inter_ready) begin
                            cnt_r     <= '0;
                            ctrl_en_r <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else if (cnt_r >= DONE_LIM) begin
                            cnt_r         <= '0;
                            timeout_err_r <= 1'b1;
                            ctrl_en_r     <= 1'b0;
                            state_r       <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    default: begin
                        cnt_r     <= '0;
                        ctrl_en_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Directed bench for interboard_tx_scheduler (NUM_REQ=3, FIX_PRIO0=1,
// START_TO=16, DONE_TO=100). Inputs change and outputs are sampled 1 time
// unit after the rising edge.
module tb_interboard_tx_scheduler;
    import bingo_inter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       interboard_rst;
    logic       busy;
    logic       timeout_err;
    logic [2:0] last_grant;

    int tests = 0;
    int fails = 0;

    interboard_tx_scheduler_if #(.NUM_REQ(3)) bus ();

    interboard_tx_scheduler #(
        .NUM_REQ   (3),
        .FIX_PRIO0 (1),
        .START_TO  (16),
        .DONE_TO   (100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .bus            (bus),
        .busy           (busy),
        .last_grant     (last_grant),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full message: accept, pulse, 5 busy cycles, done
    task automatic send_one(input string tag, input logic [2:0] exp_g, input bit drop, input bit raise0);
        #1;
        chk({tag, "_rdy"}, 32'(bus.req_ready), 32'(exp_g));
        step();
        chk({tag, "_tx"}, 32'(bus.transmit), 32'd1);
        chk({tag, "_lg"}, 32'(last_grant), 32'(exp_g));
        if (drop) bus.req_valid = bus.req_valid & ~exp_g;
        step();
        bus.inter_ready = 1'b0;
        repeat (5) step();
        if (raise0) bus.req_valid[0] = 1'b1;
        bus.inter_ready = 1'b1;
        step();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        interboard_rst   = 1'b0;
        bus.req_valid    = 3'b000;
        bus.req_msg_type = 9'd0;
        bus.req_number   = 15'd0;
        bus.inter_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_tx",   32'(bus.transmit),      32'd0);
        chk("rst_en",   32'(bus.ctrl_en),       32'd0);
        chk("rst_busy", 32'(busy),              32'd0);
        chk("rst_lg",   32'(last_grant),        32'd0);
        chk("rst_to",   32'(timeout_err),       32'd0);
        chk("rst_msg",  32'(bus.ctrl_msg_type), 32'd0);
        rst = 1'b0;
        step();

        // Single request from source 1
        bus.req_valid          = 3'b010;
        bus.req_msg_type[5:3]  = 3'd2;
        bus.req_number[9:5]    = 5'd17;
        #1;
        chk("one_rdy", 32'(bus.req_ready), 32'd2);
        step();
        chk("one_tx",   32'(bus.transmit),      32'd1);
        chk("one_en",   32'(bus.ctrl_en),       32'd1);
        chk("one_msg",  32'(bus.ctrl_msg_type), 32'd2);
        chk("one_num",  32'(bus.ctrl_number),   32'd17);
        chk("one_busy", 32'(busy),              32'd1);
        chk("one_rdy0", 32'(bus.req_ready),     32'd0);
        bus.req_valid = 3'b000;
        step();
        chk("one_tx_lo", 32'(bus.transmit), 32'd0);
        bus.inter_ready = 1'b0;
        step();
        step();
        chk("one_en_fl", 32'(bus.ctrl_en), 32'd1);
        bus.inter_ready = 1'b1;
        step();
        chk("one_en_lo", 32'(bus.ctrl_en),       32'd0);
        chk("one_hold",  32'(bus.ctrl_number),   32'd17);
        chk("one_holdm", 32'(bus.ctrl_msg_type), 32'd2);

        // Round robin between sources 1 and 2 (pointer now at 2)
        bus.req_valid          = 3'b110;
        bus.req_msg_type[8:6]  = 3'd3;
        bus.req_number[14:10]  = 5'd4;
        send_one("rr1", 3'b100, 1'b0, 1'b0);
        send_one("rr2", 3'b010, 1'b0, 1'b0);
        send_one("rr3", 3'b100, 1'b0, 1'b0);
        send_one("rr4", 3'b010, 1'b0, 1'b0);

        // Source 0 raised while source 2 in flight wins ahead of pending 1
        send_one("pri_a", 3'b100, 1'b0, 1'b1);
        send_one("pri_b", 3'b001, 1'b1, 1'b0);
        send_one("pri_c", 3'b010, 1'b0, 1'b0);
        bus.req_valid = 3'b000;

        // Start timeout: inter_ready never falls
        bus.req_valid          = 3'b100;
        bus.req_msg_type[8:6]  = 3'd5;
        bus.req_number[14:10]  = 5'd9;
        #1;
        chk("sto_rdy", 32'(bus.req_ready), 32'd4);
        step();
        chk("sto_tx",  32'(bus.transmit),      32'd1);
        chk("sto_msg", 32'(bus.ctrl_msg_type), 32'd5);
        chk("sto_num", 32'(bus.ctrl_number),   32'd9);
        bus.req_valid = 3'b000;
        repeat (15) step();
        chk("sto_early", 32'(timeout_err), 32'd0);
        chk("sto_en_hi", 32'(bus.ctrl_en), 32'd1);
        step();
        chk("sto_pulse", 32'(timeout_err), 32'd1);
        chk("sto_en_lo", 32'(bus.ctrl_en), 32'd0);
        chk("sto_idle",  32'(busy),        32'd0);
        step();
        chk("sto_1cyc",  32'(timeout_err), 32'd0);

        // Done timeout: inter_ready stuck low
        bus.req_valid          = 3'b010;
        bus.req_msg_type[5:3]  = 3'd1;
        bus.req_number[9:5]    = 5'd31;
        #1;
        chk("dto_rdy", 32'(bus.req_ready), 32'd2);
        step();
        bus.req_valid = 3'b000;
        step();
        bus.inter_ready = 1'b0;
        step();
        repeat (99) step();
        chk("dto_early", 32'(timeout_err), 32'd0);
        chk("dto_busy",  32'(busy),        32'd1);
        step();
        chk("dto_pulse", 32'(timeout_err), 32'd1);
        chk("dto_idle",  32'(busy),        32'd0);
        chk("dto_en_lo", 32'(bus.ctrl_en), 32'd0);
        bus.inter_ready = 1'b1;
        step();
        chk("dto_1cyc",  32'(timeout_err), 32'd0);

        // Link abort while in WAIT_DONE
        bus.req_valid          = 3'b001;
        bus.req_msg_type[2:0]  = 3'd4;
        bus.req_number[4:0]    = 5'd3;
        #1;
        chk("ab_rdy", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 3'b000;
        step();
        bus.inter_ready = 1'b0;
        step();
        step();
        step();
        interboard_rst = 1'b1;
        step();
        chk("ab_idle", 32'(busy),        32'd0);
        chk("ab_en",   32'(bus.ctrl_en), 32'd0);
        chk("ab_to",   32'(timeout_err), 32'd0);
        bus.inter_ready = 1'b1;
        bus.req_valid   = 3'b010;
        #1;
        chk("ab_nordy", 32'(bus.req_ready), 32'd0);
        step();
        chk("ab_stay", 32'(busy), 32'd0);
        interboard_rst = 1'b0;
        #1;
        chk("ab_rdy2", 32'(bus.req_ready), 32'd2);
        bus.inter_ready = 1'b0;
        #1;
        chk("ir_block", 32'(bus.req_ready), 32'd0);
        bus.inter_ready = 1'b1;

        // Async reset in the middle of ISSUE
        #1;
        chk("ar_rdy", 32'(bus.req_ready), 32'd2);
        step();
        chk("ar_tx", 32'(bus.transmit), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_tx0",   32'(bus.transmit),    32'd0);
        chk("ar_en0",   32'(bus.ctrl_en),     32'd0);
        chk("ar_busy0", 32'(busy),            32'd0);
        chk("ar_lg0",   32'(last_grant),      32'd0);
        chk("ar_num0",  32'(bus.ctrl_number), 32'd0);
        rst           = 1'b0;
        bus.req_valid = 3'b110;
        #1;
        chk("ar_ptr", 32'(bus.req_ready), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
